mrd_fsm_ctrl: RTL

MRD_FSM_CTRL -- requirements
Module: mrd_fsm_ctrl

---
 rtl/mrd_pkg.sv | 21 ++
 rtl/mrd_src_cnt.sv | 78 +++++++
 rtl/mrd_fsm_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mrd_pkg.sv
// Shared definitions for the MRD frame controller and the sink writer:
// controller state encoding, sink beat-count width and the beat-count helper.
package mrd_pkg;

  localparam int BEAT_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SINK    = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_RD      = 3'd3,
    ST_WAIT_WR = 3'd4,
    ST_SOURCE  = 3'd5
  } mrd_state_e;

  // Four samples per beat; a partial trailing beat still counts as a beat.
  function automatic logic [BEAT_W-1:0] calc_beats(input logic [11:0] dft_size);
    return BEAT_W'(({1'b0, dft_size} + 13'd3) >> 2);
  endfunction

endpackage

// File: rtl/mrd_src_cnt.sv
// Source-side beat sequencer: walks the beat index 0..beats-1 under a
// valid/ready handshake and flags the first and last beats.
module mrd_src_cnt
  import mrd_pkg::*;
#(
  parameter int wADDR = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BEAT_W-1:0] beats,
  input  logic              src_ready,
  output logic              src_valid,
  output logic              src_sop,
  output logic              src_eop,
  output logic [wADDR-1:0]  src_addr,
  output logic              done
);

  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic [BEAT_W-1:0] idx_q, idx_d;
  logic [BEAT_W-1:0] idx_nxt;
  logic [BEAT_W-1:0] last_idx;

  assign idx_nxt  = idx_q + 1'b1;
  assign last_idx = beats - 1'b1;

  // The last beat leaving the interface ends the Source phase.
  assign done = valid_q & src_ready & eop_q;

  assign src_valid = valid_q;
  assign src_sop   = sop_q;
  assign src_eop   = eop_q;
  assign src_addr  = wADDR'(idx_q);

  // Next beat index and flags; everything holds while the sink stalls.
  always_comb begin
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    idx_d   = idx_q;
    if (load) begin
      valid_d = 1'b1;
      idx_d   = '0;
      sop_d   = 1'b1;
      eop_d   = (beats == BEAT_W'(1));
    end else if (valid_q && src_ready) begin
      if (eop_q) begin
        valid_d = 1'b0;
        idx_d   = '0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
      end else begin
        idx_d = idx_nxt;
        sop_d = 1'b0;
        eop_d = (idx_nxt == last_idx);
      end
    end
  end

  // Handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/mrd_fsm_ctrl.sv
// Frame controller for the mixed-radix DFT: collects sink beats, runs one
// read/write-back pass per radix stage, then streams the result out.
module mrd_fsm_ctrl
  import mrd_pkg::*;
#(
  parameter int wADDR   = 8,
  parameter int GAP_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [11:0]      dft_size,
  input  logic [2:0]       num_stages,
  input  logic             overTime,
  input  logic             rd_last,
  input  logic             wr_done,
  input  logic             src_ready,
  output logic [2:0]       fsm,
  output logic             rd_start,
  output logic [2:0]       stage_idx,
  output logic             src_valid,
  output logic             src_sop,
  output logic             src_eop,
  output logic [wADDR-1:0] src_addr,
  output logic             err_overtime
);

  localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  mrd_state_e        state_q, state_d;
  logic [2:0]        stage_q, stage_d;
  logic [2:0]        nstg_q, nstg_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [BEAT_W-1:0] sink_cnt_q, sink_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              err_q, err_d;
  logic              rd_start_q, rd_start_d;
  logic              src_load;
  logic              src_done;

  assign fsm          = state_q;
  assign rd_start     = rd_start_q;
  assign stage_idx    = stage_q;
  assign err_overtime = err_q;

  // Next state and frame bookkeeping; rd_start and the source load are
  // derived from the transition so they land in the first cycle of the state.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    nstg_d     = nstg_q;
    beats_d    = beats_q;
    sink_cnt_d = sink_cnt_q;
    gap_d      = gap_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_SINK;
          stage_d    = '0;
          beats_d    = calc_beats(dft_size);
          nstg_d     = (num_stages == 3'd0) ? 3'd1 : num_stages;
          sink_cnt_d = BEAT_W'(1);
          err_d      = 1'b0;
        end
      end
      ST_SINK: begin
        if (overTime) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (in_valid) begin
          if (sink_cnt_q != '1) sink_cnt_d = sink_cnt_q + 1'b1;
        end else if (sink_cnt_q != '0) begin
          state_d = ST_WAIT_RD;
          gap_d   = '0;
        end
      end
      ST_WAIT_RD: begin
        if (gap_q == GAP_W'(GAP_LAST)) begin
          state_d = ST_RD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_RD: begin
        if (rd_last) state_d = ST_WAIT_WR;
      end
      ST_WAIT_WR: begin
        if (wr_done) begin
          if (stage_q == nstg_q - 3'd1) begin
            state_d = (beats_q == '0) ? ST_IDLE : ST_SOURCE;
          end else begin
            stage_d = stage_q + 3'd1;
            state_d = ST_RD;
          end
        end
      end
      ST_SOURCE: begin
        if (src_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rd_start_d = (state_d == ST_RD) && (state_q != ST_RD);
    src_load   = (state_d == ST_SOURCE) && (state_q != ST_SOURCE);
  end

  // State and frame registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      stage_q    <= '0;
      nstg_q     <= '0;
      beats_q    <= '0;
      sink_cnt_q <= '0;
      gap_q      <= '0;
      err_q      <= 1'b0;
      rd_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      nstg_q     <= nstg_d;
      beats_q    <= beats_d;
      sink_cnt_q <= sink_cnt_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      rd_start_q <= rd_start_d;
    end
  end

  mrd_src_cnt #(
    .wADDR(wADDR)
  ) u_src_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (src_load),
    .beats    (beats_q),
    .src_ready(src_ready),
    .src_valid(src_valid),
    .src_sop  (src_sop),
    .src_eop  (src_eop),
    .src_addr (src_addr),
    .done     (src_done)
  );

endmodule
